fm_mpx_dds_modulator: RTL
=========================

// Module: fm_mpx_dds_modulator
// PURPOSE
//  Multi-channel FM modulator for the audio transmit path. Accepts frames of NUM_CH offset-binary ADC
//  samples, averages the enabled channels in a sequential per-channel pass, and scales the result by a
//  soft-mute ramp gain. The scaled value drives a phase-continuous DDS: freq = center + sample*move.
//  Sits between the ADC capture blocks and the FM output pin.
// PARAMETERS
//  NUM_CH     2   audio channels per frame (>=1)
//  IN_W       12  ADC sample width, offset binary
//  PHASE_W    32  phase accumulator / frequency word width
//  OUT_W      12  phase bits exported on fm_wave (<=PHASE_W)
//  RAMP_LOG2  8   ramp resolution; gain runs 0..2^RAMP_LOG2, one step per accepted frame
// PORTS
//  clk_in      in   1             single clock (DDS rate)
//  rst_n       in   1             asynchronous reset, active low
//  s_valid     in   1             sample frame valid
//  s_ready     out  1             frame accepted on s_valid&s_ready
//  s_data      in   NUM_CH*IN_W   channel k at bits [k*IN_W +: IN_W]
//  ch_enable   in   NUM_CH        per-channel include mask, sampled at accept
//  center_fre  in   PHASE_W       carrier frequency word (shadowed)
//  move_fre    in   PHASE_W       deviation word per sample LSB (shadowed)
//  cfg_load    in   1             strobe: capture center_fre/move_fre into shadow
//  tx_en       in   1             level: 1 = transmit, 0 = mute
//  fm_wave     out  OUT_W         phase_acc[PHASE_W-1 -: OUT_W]
//  fm_bit      out  1             phase_acc MSB, gated to 0 in MUTED
//  tx_state    out  2             0 MUTED, 1 RAMP_UP, 2 ACTIVE, 3 RAMP_DOWN
// BEHAVIOUR
//  Reset: phase_acc, freq_word, shadow/active cfg, gain, accumulator = 0; tx_state MUTED; fm_wave 0,
//   fm_bit 0; s_ready 1 from first edge after release. Reset mid-frame drops the in-flight frame.
//  Ingest: s_ready = sequencer idle. Accept at edge T; channel k (converted to signed x - 2^(IN_W-1),
//   zero if masked) is added at edge T+1+k. s_ready is high again in cycle T+NUM_CH+1 -> max one frame
//   per NUM_CH+1 clocks.
//  Average: sum width IN_W+clog2(NUM_CH), arithmetic shift right by clog2(NUM_CH) regardless of mask;
//   no saturation required. Scaled = (avg*gain)>>>RAMP_LOG2, registered at T+NUM_CH+1.
//  Freq update: freq_word = active_center + scaled*active_move, truncated mod 2^PHASE_W, registered at
//   T+NUM_CH+2 (the frame update). phase_acc += freq_word every clock, free-running wrap, never cleared
//   except by reset -> phase continuous across all retunes.
//  Config: cfg_load writes shadow; active cfg copies shadow at each frame update. cfg_load in the same
//   cycle as an update: active gets the old shadow, new value applies at the following update.
//  Ramp FSM, evaluated at each frame update:
//   MUTED: gain 0; tx_en=1 -> RAMP_UP. fm_bit forced 0; phase_acc runs at center only.
//   RAMP_UP: gain+1 per frame; gain=2^RAMP_LOG2 -> ACTIVE; tx_en=0 -> RAMP_DOWN from current gain.
//   ACTIVE: gain max; tx_en=0 -> RAMP_DOWN.
//   RAMP_DOWN: gain-1 per frame; gain=0 -> MUTED; tx_en=1 -> RAMP_UP from current gain.
//  No frames arriving: FSM and freq_word hold; carrier continues.
// STRUCTURE
//  Shared package fm_pkg: tx_state encodings, SEQ_IDLE/SEQ_ACC codes, midscale/offset helper function.
//  One sub-module fm_phase_acc: phase accumulator, fm_wave slice, gated fm_bit.
//  Top holds the ingest sequencer, averaging, ramp FSM, shadow/active config and multiply.
// TESTING (NUM_CH=2, IN_W=12, PHASE_W=32, RAMP_LOG2=2 unless stated)
//  1 Assert rst_n low mid-frame -> all outputs 0, tx_state 0; s_ready 1 one clock after release.
//  2 center=0x1000_0000, tx_en=1, all samples 0x800 -> ACTIVE after 4 frames; fm_bit period 16 clocks.
//  3 Data {0xC00,0x800}, mask 2'b11 -> avg 512; move=105 -> freq_word = center+53760, update at T+4.
//  4 Constant avg 1024, tx_en rise -> deviation multiples 256,512,768,1024; tx_en=0 after gain 2 -> 256,0, MUTED.
//  5 cfg_load in update cycle while streaming -> new center on next update; phase_acc never resets.
//  6 s_valid held high -> accepts at T, T+3, T+6; s_ready low exactly 2 cycles each frame.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared types and helpers for the FM MPX DDS modulator.
package fm_pkg;

    // Transmit ramp states, exported directly on tx_state.
    typedef enum logic [1:0] {
        TxMuted    = 2'd0,
        TxRampUp   = 2'd1,
        TxActive   = 2'd2,
        TxRampDown = 2'd3
    } tx_state_e;

    // Ingest sequencer states.
    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_ACC  = 1'b1
    } seq_state_e;

    // Offset-binary midscale 2^(width-1); subtracting it gives the signed sample.
    function automatic logic [31:0] midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fm_phase_acc.sv
// Phase-continuous DDS accumulator with exported phase slice and gated MSB.
module fm_phase_acc #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned OUT_W   = 12
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               mute,
    output logic [OUT_W-1:0]   fm_wave,
    output logic               fm_bit
);

    logic [PHASE_W-1:0] phase_acc_q;

    // Free-running accumulator; only reset clears it, so retunes never break phase.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            phase_acc_q <= '0;
        end else begin
            phase_acc_q <= phase_acc_q + freq_word;
        end
    end

    assign fm_wave = phase_acc_q[PHASE_W-1 -: OUT_W];
    assign fm_bit  = phase_acc_q[PHASE_W-1] & ~mute;

endmodule

// File: rtl/fm_mpx_dds_modulator.sv
// Multi-channel FM modulator: averages enabled ADC channels, applies a soft-mute
// ramp gain and retunes a phase-continuous DDS once per accepted frame.
module fm_mpx_dds_modulator
    import fm_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned IN_W      = 12,
    parameter int unsigned PHASE_W   = 32,
    parameter int unsigned OUT_W     = 12,
    parameter int unsigned RAMP_LOG2 = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [NUM_CH*IN_W-1:0] s_data,
    input  logic [NUM_CH-1:0]      ch_enable,
    input  logic [PHASE_W-1:0]     center_fre,
    input  logic [PHASE_W-1:0]     move_fre,
    input  logic                   cfg_load,
    input  logic                   tx_en,
    output logic [OUT_W-1:0]       fm_wave,
    output logic                   fm_bit,
    output logic [1:0]             tx_state
);

    localparam int unsigned CH_LOG = $clog2(NUM_CH);
    localparam int unsigned SUM_W  = IN_W + CH_LOG;
    localparam int unsigned IDX_W  = (NUM_CH > 1) ? CH_LOG : 1;
    localparam int unsigned GAIN_W = RAMP_LOG2 + 1;

    localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(1) << RAMP_LOG2;
    localparam logic [IDX_W-1:0]  LAST_CH  = IDX_W'(NUM_CH - 1);
    localparam logic [IN_W-1:0]   MID      = IN_W'(midscale(IN_W));

    logic                    rdy_en_q;
    seq_state_e              seq_q;
    logic [IDX_W-1:0]        ch_idx_q;
    logic [NUM_CH*IN_W-1:0]  frame_q;
    logic [NUM_CH-1:0]       mask_q;
    logic signed [SUM_W-1:0] sum_q;
    logic                    sum_done_q;
    logic [PHASE_W-1:0]      scaled_q;
    logic                    scale_done_q;
    logic [PHASE_W-1:0]      center_sh_q;
    logic [PHASE_W-1:0]      move_sh_q;
    logic [PHASE_W-1:0]      center_act_q;
    logic [PHASE_W-1:0]      move_act_q;
    logic [PHASE_W-1:0]      applied_q;
    logic [GAIN_W-1:0]       gain_q;
    tx_state_e               tx_state_q;

    logic                      accept;
    logic [IN_W-1:0]           ch_raw;
    logic signed [IN_W-1:0]    ch_val;
    logic signed [PHASE_W-1:0] sum_ext;
    logic signed [PHASE_W-1:0] avg;
    logic signed [PHASE_W-1:0] prod;
    logic signed [PHASE_W-1:0] scaled;
    logic [GAIN_W-1:0]         gain_up;
    logic [GAIN_W-1:0]         gain_dn;
    logic [PHASE_W-1:0]        freq_word;

    assign s_ready = rdy_en_q && (seq_q == SEQ_IDLE);
    assign accept  = s_valid && s_ready;
    assign gain_up = gain_q + GAIN_W'(1);
    assign gain_dn = gain_q - GAIN_W'(1);

    // Current channel as a signed sample; masked channels contribute zero.
    always_comb begin
        ch_raw = frame_q[ch_idx_q*IN_W +: IN_W];
        ch_val = mask_q[ch_idx_q] ? $signed(ch_raw - MID) : '0;
    end

    // Average (fixed divide by channel count) and ramp gain scaling, all at phase width.
    always_comb begin
        sum_ext = PHASE_W'(sum_q);
        avg     = sum_ext >>> CH_LOG;
        prod    = avg * $signed(PHASE_W'(gain_q));
        scaled  = prod >>> RAMP_LOG2;
    end

    // All three inputs change together on the frame update, so this behaves as a
    // registered frequency word.
    assign freq_word = center_act_q + applied_q * move_act_q;

    // s_ready stays low while in reset and rises on the first clock after release.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    // Ingest sequencer: latch the frame, then add one channel per clock.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            seq_q      <= SEQ_IDLE;
            ch_idx_q   <= '0;
            frame_q    <= '0;
            mask_q     <= '0;
            sum_q      <= '0;
            sum_done_q <= 1'b0;
        end else begin
            sum_done_q <= 1'b0;
            unique case (seq_q)
                SEQ_IDLE: begin
                    if (accept) begin
                        frame_q  <= s_data;
                        mask_q   <= ch_enable;
                        ch_idx_q <= '0;
                        seq_q    <= SEQ_ACC;
                    end
                end
                SEQ_ACC: begin
                    if (ch_idx_q == '0) begin
                        sum_q <= SUM_W'(ch_val);
                    end else begin
                        sum_q <= sum_q + SUM_W'(ch_val);
                    end
                    if (ch_idx_q == LAST_CH) begin
                        seq_q      <= SEQ_IDLE;
                        sum_done_q <= 1'b1;
                    end else begin
                        ch_idx_q <= ch_idx_q + IDX_W'(1);
                    end
                end
                default: seq_q <= SEQ_IDLE;
            endcase
        end
    end

    // Capture the scaled deviation one clock after the sum completes.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            scaled_q     <= '0;
            scale_done_q <= 1'b0;
        end else begin
            scale_done_q <= sum_done_q;
            if (sum_done_q) begin
                scaled_q <= scaled;
            end
        end
    end

    // Shadow configuration written by the host strobe.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            center_sh_q <= '0;
            move_sh_q   <= '0;
        end else if (cfg_load) begin
            center_sh_q <= center_fre;
            move_sh_q   <= move_fre;
        end
    end

    // Frame update: adopt shadow config and new deviation, step the ramp FSM.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            center_act_q <= '0;
            move_act_q   <= '0;
            applied_q    <= '0;
            gain_q       <= '0;
            tx_state_q   <= TxMuted;
        end else if (scale_done_q) begin
            center_act_q <= center_sh_q;
            move_act_q   <= move_sh_q;
            applied_q    <= scaled_q;
            unique case (tx_state_q)
                TxMuted: begin
                    if (tx_en) begin
                        gain_q     <= gain_up;
                        tx_state_q <= (gain_up == GAIN_MAX) ? TxActive : TxRampUp;
                    end
                end
                TxRampUp, TxRampDown: begin
                    if (tx_en) begin
                        gain_q     <= gain_up;
                        tx_state_q <= (gain_up == GAIN_MAX) ? TxActive : TxRampUp;
                    end else begin
                        gain_q     <= gain_dn;
                        tx_state_q <= (gain_dn == '0) ? TxMuted : TxRampDown;
                    end
                end
                TxActive: begin
                    if (!tx_en) begin
                        gain_q     <= gain_dn;
                        tx_state_q <= (gain_dn == '0) ? TxMuted : TxRampDown;
                    end
                end
                default: tx_state_q <= TxMuted;
            endcase
        end
    end

    assign tx_state = tx_state_q;

    fm_phase_acc #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W)
    ) u_phase_acc (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .freq_word (freq_word),
        .mute      (tx_state_q == TxMuted),
        .fm_wave   (fm_wave),
        .fm_bit    (fm_bit)
    );

endmodule
